// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display path: active-low segment
// patterns, active-low digit-select codes and the receiver FSM encoding.
package seg7_pkg;

    // Active-low segment patterns, bit0=a .. bit6=g (dp not included)
    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;

    // Active-low one-hot digit selects
    localparam logic [3:0] SEL_D0   = 4'b1110;
    localparam logic [3:0] SEL_D1   = 4'b1101;
    localparam logic [3:0] SEL_D2   = 4'b1011;
    localparam logic [3:0] SEL_D3   = 4'b0111;
    localparam logic [3:0] SEL_NONE = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        HELD  = 2'd2
    } rx_state_t;

    typedef struct packed {
        logic       vld;
        logic [1:0] idx;
    } sel_t;

    // Map a digit-select code to a slot index; anything not one-hot-low is invalid
    function automatic sel_t sel_decode(input logic [3:0] bits);
        sel_t r;
        case (bits)
            SEL_D0:  r = '{vld: 1'b1, idx: 2'd0};
            SEL_D1:  r = '{vld: 1'b1, idx: 2'd1};
            SEL_D2:  r = '{vld: 1'b1, idx: 2'd2};
            SEL_D3:  r = '{vld: 1'b1, idx: 2'd3};
            default: r = '{vld: 1'b0, idx: 2'd0};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seg4_scan_rx_if.sv
// Display bus plus recovered-word outputs of the scan receiver.
interface seg4_scan_rx_if;
    logic [7:0]  sm_seg;
    logic [3:0]  sm_bit;
    logic [15:0] digits;
    logic        digits_vld;
    logic        frame_err;
    logic        no_signal;

    // Side that drives the display bus and watches the recovered word
    modport master (
        output sm_seg, sm_bit,
        input  digits, digits_vld, frame_err, no_signal
    );

    // Receiver side
    modport slave (
        input  sm_seg, sm_bit,
        output digits, digits_vld, frame_err, no_signal
    );
endinterface

// File: rtl/seg7_pattern_decode.sv
// Combinational 7-segment pattern to BCD digit decoder; unknown patterns give F + bad.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] i_pat,
    output logic [3:0] o_val,
    output logic       o_bad
);

    // Look the pattern up against the shared digit table
    always_comb begin
        o_val = 4'hF;
        o_bad = 1'b1;
        case (i_pat)
            SEG_0:   begin o_val = 4'd0; o_bad = 1'b0; end
            SEG_1:   begin o_val = 4'd1; o_bad = 1'b0; end
            SEG_2:   begin o_val = 4'd2; o_bad = 1'b0; end
            SEG_3:   begin o_val = 4'd3; o_bad = 1'b0; end
            SEG_4:   begin o_val = 4'd4; o_bad = 1'b0; end
            SEG_5:   begin o_val = 4'd5; o_bad = 1'b0; end
            SEG_6:   begin o_val = 4'd6; o_bad = 1'b0; end
            SEG_7:   begin o_val = 4'd7; o_bad = 1'b0; end
            SEG_8:   begin o_val = 4'd8; o_bad = 1'b0; end
            SEG_9:   begin o_val = 4'd9; o_bad = 1'b0; end
            default: begin o_val = 4'hF; o_bad = 1'b1; end
        endcase
    end

endmodule

// File: rtl/seg4_scan_rx.sv
// 4-digit multiplexed 7-segment scan receiver: synchronises the display bus,
// captures each digit once per stable dwell and reassembles the 16-bit word.
module seg4_scan_rx
    import seg7_pkg::*;
#(
    parameter int STABLE_CYC  = 256,
    parameter int TIMEOUT_CYC = 2400000
) (
    input  logic clk_24m,
    input  logic rst_n,
    seg4_scan_rx_if.slave bus
);

    localparam int SW = $clog2(STABLE_CYC);
    localparam int IW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYC - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYC - 1);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(TIMEOUT_CYC);

    logic [7:0]       r_seg_m, r_seg_s, r_seg_p;
    logic [3:0]       r_bit_m, r_bit_s, r_bit_p;
    rx_state_t        r_state, w_state_nx;
    logic [SW-1:0]    r_stab;
    logic [IW-1:0]    r_idle;
    logic [3:0][3:0]  r_slot;
    logic [3:0]       r_mask, r_err;
    logic [15:0]      r_digits;
    logic             r_vld, r_ferr, r_nosig;

    sel_t             w_sel;
    logic             w_change;
    logic             w_capture;
    logic             w_timeout;
    logic             w_frame_done;
    logic [3:0]       w_cap_bit;
    logic [3:0]       w_val;
    logic             w_bad;

    seg7_pattern_decode u_dec (
        .i_pat (r_seg_s[6:0]),
        .o_val (w_val),
        .o_bad (w_bad)
    );

    assign w_sel        = sel_decode(r_bit_s);
    assign w_change     = (r_seg_s != r_seg_p) || (r_bit_s != r_bit_p);
    assign w_frame_done = (r_mask == 4'hF);
    assign w_timeout    = (r_idle == IDLE_LAST) && !w_capture;
    assign w_cap_bit    = w_capture ? (4'b0001 << w_sel.idx) : 4'b0000;

    // Two-flop synchronisers plus a previous-sample copy for change detection
    always_ff @(posedge clk_24m or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_m <= 8'hFF;
            r_seg_s <= 8'hFF;
            r_seg_p <= 8'hFF;
            r_bit_m <= 4'hF;
            r_bit_s <= 4'hF;
            r_bit_p <= 4'hF;
        end else begin
            r_seg_m <= bus.sm_seg;
            r_seg_s <= r_seg_m;
            r_seg_p <= r_seg_s;
            r_bit_m <= bus.sm_bit;
            r_bit_s <= r_bit_m;
            r_bit_p <= r_bit_s;
        end
    end

    // FSM state register
    always_ff @(posedge clk_24m or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // FSM next-state: any bus change restarts the dwell or drops to IDLE on a bad select
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE: begin
                if (w_sel.vld) w_state_nx = DWELL;
                else           w_state_nx = IDLE;
            end
            DWELL: begin
                if (w_change)                w_state_nx = w_sel.vld ? DWELL : IDLE;
                else if (r_stab == STAB_LAST) w_state_nx = HELD;
                else                          w_state_nx = DWELL;
            end
            HELD: begin
                if (w_change) w_state_nx = w_sel.vld ? DWELL : IDLE;
                else          w_state_nx = HELD;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // FSM output: single capture strobe at the end of an unbroken dwell
    always_comb begin
        w_capture = 1'b0;
        if ((r_state == DWELL) && !w_change && (r_stab == STAB_LAST)) w_capture = 1'b1;
        else                                                          w_capture = 1'b0;
    end

    // Stability counter: counts unchanged samples while dwelling, zero otherwise
    always_ff @(posedge clk_24m or negedge rst_n) begin
        if (!rst_n) begin
            r_stab <= '0;
        end else if ((r_state == DWELL) && !w_change && (r_stab != STAB_LAST)) begin
            r_stab <= r_stab + SW'(1);
        end else begin
            r_stab <= '0;
        end
    end

    // Slot storage; a recapture of the same digit simply overwrites it
    always_ff @(posedge clk_24m or negedge rst_n) begin
        if (!rst_n) begin
            r_slot <= '0;
        end else if (w_capture) begin
            r_slot[w_sel.idx] <= w_val;
        end else begin
            r_slot <= r_slot;
        end
    end

    // Frame mask/error bits; completion or timeout starts a new frame seeded by any same-cycle capture
    always_ff @(posedge clk_24m or negedge rst_n) begin
        if (!rst_n) begin
            r_mask <= 4'h0;
            r_err  <= 4'h0;
        end else if (w_frame_done || w_timeout) begin
            r_mask <= w_cap_bit;
            r_err  <= w_bad ? w_cap_bit : 4'h0;
        end else begin
            r_mask <= r_mask | w_cap_bit;
            r_err  <= (r_err & ~w_cap_bit) | (w_bad ? w_cap_bit : 4'h0);
        end
    end

    // Word delivery: registered word, error flag and one-cycle valid pulse
    always_ff @(posedge clk_24m or negedge rst_n) begin
        if (!rst_n) begin
            r_digits <= 16'h0000;
            r_ferr   <= 1'b0;
            r_vld    <= 1'b0;
        end else if (w_frame_done) begin
            r_digits <= r_slot;
            r_ferr   <= |r_err;
            r_vld    <= 1'b1;
        end else begin
            r_vld    <= 1'b0;
        end
    end

    // Idle watchdog: saturating count since the last capture, drives no_signal
    always_ff @(posedge clk_24m or negedge rst_n) begin
        if (!rst_n) begin
            r_idle  <= '0;
            r_nosig <= 1'b1;
        end else if (w_capture) begin
            r_idle  <= '0;
            r_nosig <= 1'b0;
        end else begin
            if (r_idle != IDLE_MAX) r_idle <= r_idle + IW'(1);
            else                    r_idle <= r_idle;
            if (w_timeout) r_nosig <= 1'b1;
            else           r_nosig <= r_nosig;
        end
    end

    assign bus.digits     = r_digits;
    assign bus.digits_vld = r_vld;
    assign bus.frame_err  = r_ferr;
    assign bus.no_signal  = r_nosig;

endmodule

// File: tb/tb_seg4_scan_rx.sv
// Directed self-checking bench for seg4_scan_rx with STABLE_CYC=4, TIMEOUT_CYC=200.
module tb_seg4_scan_rx;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;
    int   vld_cnt;
    int   vld_base;

    seg4_scan_rx_if u_if ();

    seg4_scan_rx #(
        .STABLE_CYC  (4),
        .TIMEOUT_CYC (200)
    ) dut (
        .clk_24m (clk),
        .rst_n   (rst_n),
        .bus     (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count cycles on which the valid pulse is high
    always @(negedge clk) begin
        if (u_if.digits_vld === 1'b1) vld_cnt = vld_cnt + 1;
    end

    // Bench's own active-low digit patterns, dp off
    function automatic logic [7:0] seg_of(input logic [3:0] d);
        logic [7:0] p;
        case (d)
            4'd0: p = 8'hC0;
            4'd1: p = 8'hF9;
            4'd2: p = 8'hA4;
            4'd3: p = 8'hB0;
            4'd4: p = 8'h99;
            4'd5: p = 8'h92;
            4'd6: p = 8'h82;
            4'd7: p = 8'hF8;
            4'd8: p = 8'h80;
            4'd9: p = 8'h90;
            default: p = 8'hFF;
        endcase
        return p;
    endfunction

    function automatic logic [3:0] sel_of(input int i);
        logic [3:0] one;
        one = 4'b0001 << i;
        return ~one;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        assert (obs === exp) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] b, input logic [7:0] s, input int n);
        u_if.sm_bit = b;
        u_if.sm_seg = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input logic [15:0] w, input int n);
        for (int i = 0; i < 4; i++) drive(sel_of(i), seg_of(w[i*4 +: 4]), n);
    endtask

    initial begin
        n_cmp   = 0;
        n_fail  = 0;
        vld_cnt = 0;
        rst_n   = 1'b0;
        u_if.sm_bit = 4'hF;
        u_if.sm_seg = 8'hFF;
        repeat (3) @(negedge clk);
        chk("rst_digits", 32'(u_if.digits), 32'h0000);
        chk("rst_vld",    32'(u_if.digits_vld), 32'd0);
        chk("rst_ferr",   32'(u_if.frame_err), 32'd0);
        chk("rst_nosig",  32'(u_if.no_signal), 32'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: clean scan of 1234
        vld_base = vld_cnt;
        scan(16'h1234, 20);
        chk("t1_vld_pulses", 32'(vld_cnt - vld_base), 32'd1);
        chk("t1_digits", 32'(u_if.digits), 32'h1234);
        chk("t1_ferr",   32'(u_if.frame_err), 32'd0);
        chk("t1_nosig",  32'(u_if.no_signal), 32'd0);

        // 2: 2-cycle blank glitch in the middle of d1
        vld_base = vld_cnt;
        drive(sel_of(0), seg_of(4'd8), 20);
        drive(sel_of(1), seg_of(4'd7), 10);
        drive(sel_of(1), 8'hFF, 2);
        drive(sel_of(1), seg_of(4'd7), 10);
        drive(sel_of(2), seg_of(4'd6), 20);
        drive(sel_of(3), seg_of(4'd5), 20);
        chk("t2_vld_pulses", 32'(vld_cnt - vld_base), 32'd1);
        chk("t2_digits", 32'(u_if.digits), 32'h5678);
        chk("t2_ferr",   32'(u_if.frame_err), 32'd0);

        // 3: undecodable d2, then a clean frame
        vld_base = vld_cnt;
        drive(sel_of(0), seg_of(4'd6), 20);
        drive(sel_of(1), seg_of(4'd7), 20);
        drive(sel_of(2), 8'hFF, 20);
        drive(sel_of(3), seg_of(4'd9), 20);
        chk("t3_vld_pulses", 32'(vld_cnt - vld_base), 32'd1);
        chk("t3_digits", 32'(u_if.digits), 32'h9F76);
        chk("t3_ferr",   32'(u_if.frame_err), 32'd1);
        scan(16'h9876, 20);
        chk("t3_clean_digits", 32'(u_if.digits), 32'h9876);
        chk("t3_clean_ferr",   32'(u_if.frame_err), 32'd0);

        // 4: partial frame then no select for 250 cycles
        vld_base = vld_cnt;
        drive(sel_of(0), seg_of(4'd1), 20);
        drive(sel_of(1), seg_of(4'd2), 20);
        drive(4'b1111, 8'hFF, 150);
        chk("t4_nosig_early", 32'(u_if.no_signal), 32'd0);
        drive(4'b1111, 8'hFF, 100);
        chk("t4_nosig_late", 32'(u_if.no_signal), 32'd1);
        chk("t4_no_vld",     32'(vld_cnt - vld_base), 32'd0);
        chk("t4_digits_held", 32'(u_if.digits), 32'h9876);
        vld_base = vld_cnt;
        scan(16'h0000, 20);
        chk("t4_recover_nosig", 32'(u_if.no_signal), 32'd0);
        chk("t4_recover_digits", 32'(u_if.digits), 32'h0000);
        chk("t4_recover_vld", 32'(vld_cnt - vld_base), 32'd1);

        // 5: two select lines low
        vld_base = vld_cnt;
        drive(4'b1100, seg_of(4'd3), 50);
        chk("t5_no_vld", 32'(vld_cnt - vld_base), 32'd0);
        chk("t5_state_idle", 32'(dut.r_state), 32'd0);
        scan(16'h2580, 20);
        chk("t5_after_digits", 32'(u_if.digits), 32'h2580);

        // 6: reset in the middle of d2 of a 4321 scan
        drive(sel_of(0), seg_of(4'd1), 20);
        drive(sel_of(1), seg_of(4'd2), 20);
        drive(sel_of(2), seg_of(4'd3), 10);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_digits", 32'(u_if.digits), 32'h0000);
        chk("t6_rst_vld",    32'(u_if.digits_vld), 32'd0);
        chk("t6_rst_ferr",   32'(u_if.frame_err), 32'd0);
        chk("t6_rst_nosig",  32'(u_if.no_signal), 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        vld_base = vld_cnt;
        drive(sel_of(2), seg_of(4'd3), 10);
        drive(sel_of(3), seg_of(4'd4), 20);
        chk("t6_partial_no_vld", 32'(vld_cnt - vld_base), 32'd0);
        chk("t6_partial_digits", 32'(u_if.digits), 32'h0000);
        vld_base = vld_cnt;
        scan(16'h4321, 20);
        chk("t6_full_vld", 32'(vld_cnt - vld_base), 32'd1);
        chk("t6_full_digits", 32'(u_if.digits), 32'h4321);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/seg4_scan_rx.md
Name: seg4_scan_rx

Overview:
Receive-side counterpart of the 4-digit multiplexed 7-segment driver. It samples the active-low segment bus (sm_seg) and the active-low digit-select bus (sm_bit), waits for each digit's dwell to be stable, and decodes each segment pattern back to a 4-bit value. It then reassembles the 16-bit digit word. It is used for on-board loopback self-test of the display path and as a bench monitor for display-driving logic.

Parameters:
STABLE_CYC, 256, number of consecutive identical synchronized samples required before a digit is captured (>=2).
TIMEOUT_CYC, 2400_000, cycles without any capture before no_signal asserts (0.1 s at 24 MHz).

Ports:
clk_24m  input  1  system clock, 24 MHz
rst_n  input  1  reset, asynchronous, active-low
sm_seg  input  8  segment lines, active-low: bit0=a .. bit6=g, bit7=dp
sm_bit  input  4  digit select, active-low one-hot
digits  output  16  recovered word, with digit0 in [3:0] and digit3 in [15:12]
digits_vld  output  1  one-cycle pulse when digits updates
frame_err  output  1  set when the word just delivered contained an undecodable digit; valid while digits is held
no_signal  output  1  high when no capture has occurred for TIMEOUT_CYC cycles

Behaviour:
- Reset is asynchronous on negedge rst_n and applies to every flop, with these values:
  - digits=0, digits_vld=0, frame_err=0, no_signal=1;
  - capture mask=0, all counters=0;
  - state=IDLE.
- Input synchronisation: sm_seg and sm_bit each pass through a 2-flop synchronizer. All logic below uses the second-stage sample s_seg/s_bit.
- Select decode:
  - 1110 gives sel=0, 1101 gives sel=1, 1011 gives sel=2, 0111 gives sel=3.
  - Any other code (1111, or more than one line low) is sel_invalid.
- Segment decode uses s_seg[6:0] only; dp is ignored.
  - 40 decodes to 0, 79 to 1, 24 to 2, 30 to 3, 19 to 4, 12 to 5, 02 to 6, 78 to 7, 00 to 8, 10 to 9.
  - Any other pattern decodes to value 4'hF with seg_bad=1.
- FSM states are IDLE, DWELL and HELD.
  - IDLE: go to DWELL with stab_cnt=0 when sel is valid.
  - DWELL: if s_bit or s_seg differs from the previous sample, restart with stab_cnt=0, or go to IDLE if sel is now invalid. Otherwise stab_cnt increments.
  - DWELL capture: when stab_cnt == STABLE_CYC-1, capture the digit and go to HELD.
  - HELD: on any change of s_bit or s_seg, go to DWELL (or to IDLE if sel is invalid). Exactly one capture is made per stable dwell.
- Capture:
  - The decoded value is written to slot[sel] and mask[sel] is set to 1.
  - err[sel] is set to seg_bad.
  - Re-capturing a slot that is already in the mask overwrites it (latest wins).
- Frame completion: when mask becomes 1111, on the next cycle:
  - digits={slot3,slot2,slot1,slot0};
  - digits_vld=1 for exactly 1 cycle;
  - frame_err=|err;
  - mask and err are cleared.
  - digits and frame_err then hold until the next completion.
- Latency: the last stable sample of digit 4 reaches the capture point 2+STABLE_CYC cycles after the pin change. digits_vld follows 1 cycle later.
- Timeout:
  - idle_cnt clears on every capture and otherwise increments, saturating.
  - When idle_cnt reaches TIMEOUT_CYC-1: no_signal=1, mask and err are cleared, and digits is held.
  - no_signal clears on the next capture.
- Simultaneous events:
  - If a capture and the timeout occur in the same cycle, the capture wins and no_signal is not set.
  - If a capture and frame completion occur in the same cycle, the new capture starts the next frame's mask.
- Reset mid-dwell: the partial frame is discarded and no digits_vld is produced.
- Counter widths: stab_cnt uses $clog2(STABLE_CYC) bits, idle_cnt uses $clog2(TIMEOUT_CYC+1) bits.

Decomposition:
- Shared package seg7_pkg:
  - SEG_0..SEG_9 patterns, shared with the driver side;
  - SEL_D0..SEL_D3 and SEL_NONE select codes;
  - the FSM state encoding.
- One combinational sub-module, seg7_pattern_decode: 7-bit pattern in; 4-bit value and bad flag out.

Test Plan (STABLE_CYC=4, TIMEOUT_CYC=200):
1. Drive a scan of word 16'h1234, each digit held 20 cycles in order d0..d3 -> one digits_vld pulse, digits=16'h1234, frame_err=0, no_signal=0.
2. Insert a 2-cycle glitch (sm_seg=8'hFF) mid-dwell on d1 of a 16'h5678 scan -> no extra capture, digits=16'h5678.
3. Drive d2 with pattern 8'hFF in a 9876 scan -> digits=16'h9F76, frame_err=1; the next clean frame gives frame_err=0.
4. Drive sm_bit=4'b1111 for 250 cycles after a partial frame (d0 and d1 only) -> no_signal=1 at cycle 200, no digits_vld. A following full scan of 0x0000 clears no_signal and gives digits=0.
5. Drive sm_bit=4'b1100 (two lines low) for 50 cycles -> no capture, state stays IDLE.
6. Assert rst_n=0 during d2 dwell of a 16'h4321 scan -> outputs return to reset values immediately. After release, only a complete new scan produces digits_vld.
